// File: rtl/prime_pkg.sv
// Shared types and defaults for the prime-check scheduler slice.
package prime_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 10;
    localparam int GRANT_W     = 3;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        CHECK   = 2'd2,
        RESPOND = 2'd3
    } state_t;

    // Round-robin successor of requester index g among n requesters.
    function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] g, input int n);
        return (int'(g) >= n - 1) ? '0 : g + GRANT_W'(1);
    endfunction

endpackage

// File: rtl/prime_trial_div.sv
// Iterative odd-divisor trial division: one divisor evaluated per clock while active.
module prime_trial_div
    import prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             SysClk,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    output logic [WIDTH-1:0] n,
    output logic             done,
    output logic             prime
);

    logic [WIDTH-1:0]   d;
    logic               active;
    logic [2*WIDTH-1:0] n_wide;
    logic [2*WIDTH-1:0] dsq;
    logic               rem_zero;

    assign n_wide = {{WIDTH{1'b0}}, n};
    assign dsq    = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
    // d is never zero while active; the guard only keeps idle evaluation well defined.
    assign rem_zero = (d != '0) && ((n % d) == '0);

    always_comb begin
        done  = 1'b0;
        prime = 1'b0;
        if (active) begin
            if (n < WIDTH'(2)) begin
                done = 1'b1;
            end else if (n == WIDTH'(2) || n == WIDTH'(3)) begin
                done  = 1'b1;
                prime = 1'b1;
            end else if (!n[0]) begin
                done = 1'b1;
            end else if (dsq > n_wide) begin
                done  = 1'b1;
                prime = 1'b1;
            end else if (rem_zero) begin
                done = 1'b1;
            end
        end
    end

    always_ff @(posedge SysClk) begin
        if (abort) begin
            active <= 1'b0;
            n      <= '0;
            d      <= '0;
        end else if (start) begin
            active <= 1'b1;
            n      <= num;
            d      <= WIDTH'(3);
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
            end else begin
                d <= d + WIDTH'(2);
            end
        end
    end

endmodule

// File: rtl/prime_check_scheduler.sv
// Round-robin front end sharing one trial-division prime tester among NUM_REQ requesters.
module prime_check_scheduler
    import prime_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic                     SysClk,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       ReqValid,
    input  logic [NUM_REQ*WIDTH-1:0] ReqNum,
    output logic [NUM_REQ-1:0]       ReqReady,
    output logic [NUM_REQ-1:0]       RspValid,
    output logic                     RspPrime,
    output logic [WIDTH-1:0]         RspNum,
    output logic [GRANT_W-1:0]       GrantId,
    output logic                     Busy,
    output logic [CNT_W-1:0]         ChecksDone,
    output logic [CNT_W-1:0]         PrimesFound
);

    state_t               state;
    logic [GRANT_W-1:0]   ptr;
    logic [NUM_REQ-1:0]   grant_oh;
    logic                 pick_found;
    logic [GRANT_W-1:0]   pick_id;
    logic [NUM_REQ-1:0]   pick_oh;
    logic                 sel_valid;
    logic [WIDTH-1:0]     sel_num;
    logic                 start;
    logic [WIDTH-1:0]     td_n;
    logic                 td_done;
    logic                 td_prime;
    logic [GRANT_W-1:0]   next_ptr;

    // Smallest cyclic distance from ptr wins, giving round-robin fairness.
    always_comb begin
        int best;
        int off;
        best       = NUM_REQ;
        off        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        pick_oh    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            off = (j + NUM_REQ - int'(ptr)) % NUM_REQ;
            if (ReqValid[j] && off < best) begin
                best       = off;
                pick_found = 1'b1;
                pick_id    = GRANT_W'(j);
                pick_oh    = '0;
                pick_oh[j] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_num = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) sel_num = ReqNum[i*WIDTH +: WIDTH];
        end
    end

    assign sel_valid = |(ReqValid & grant_oh);
    assign start     = (state == GRANT) && sel_valid;
    assign next_ptr  = wrap_inc(GrantId, NUM_REQ);

    prime_trial_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .SysClk (SysClk),
        .abort  (Reset),
        .start  (start),
        .num    (sel_num),
        .n      (td_n),
        .done   (td_done),
        .prime  (td_prime)
    );

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_oh    <= '0;
            ReqReady    <= '0;
            RspValid    <= '0;
            RspPrime    <= 1'b0;
            RspNum      <= '0;
            GrantId     <= '0;
            Busy        <= 1'b0;
            ChecksDone  <= '0;
            PrimesFound <= '0;
        end else begin
            ReqReady <= '0;
            RspValid <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        GrantId  <= pick_id;
                        grant_oh <= pick_oh;
                        ReqReady <= pick_oh;
                        Busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // A request withdrawn on its acceptance cycle is dropped silently.
                    if (sel_valid) begin
                        state <= CHECK;
                    end else begin
                        ptr   <= next_ptr;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CHECK: begin
                    if (td_done) begin
                        RspPrime <= td_prime;
                        RspNum   <= td_n;
                        RspValid <= grant_oh;
                        state    <= RESPOND;
                    end
                end
                RESPOND: begin
                    ChecksDone  <= ChecksDone + CNT_W'(1);
                    PrimesFound <= PrimesFound + CNT_W'(RspPrime);
                    ptr         <= next_ptr;
                    Busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_check_scheduler.sv
// Directed, table-driven bench for prime_check_scheduler.
module tb_prime_check_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 10;

    logic                     SysClk = 1'b0;
    logic                     Reset;
    logic [NUM_REQ-1:0]       ReqValid;
    logic [NUM_REQ*WIDTH-1:0] ReqNum;
    logic [NUM_REQ-1:0]       ReqReady;
    logic [NUM_REQ-1:0]       RspValid;
    logic                     RspPrime;
    logic [WIDTH-1:0]         RspNum;
    logic [2:0]               GrantId;
    logic                     Busy;
    logic [15:0]              ChecksDone;
    logic [15:0]              PrimesFound;

    prime_check_scheduler #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .SysClk      (SysClk),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqNum      (ReqNum),
        .ReqReady    (ReqReady),
        .RspValid    (RspValid),
        .RspPrime    (RspPrime),
        .RspNum      (RspNum),
        .GrantId     (GrantId),
        .Busy        (Busy),
        .ChecksDone  (ChecksDone),
        .PrimesFound (PrimesFound)
    );

    always #5 SysClk = ~SysClk;

    typedef struct {
        int req;
        int num;
        int prime;
        int k;
    } vec_t;

    vec_t vecs[14];
    int   total = 0;
    int   passed = 0;
    int   exp_checks = 0;
    int   exp_primes = 0;
    int   overlap = 0;
    int   model_primes = 0;
    int   g_ord[8];
    int   g_cnt;
    int   r_id[8];
    int   r_prime[8];
    int   r_num[8];
    int   r_cnt;

    always @(negedge SysClk) begin
        if (ReqReady != '0 && RspValid != '0) overlap++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int ref_prime(input int n);
        if (n < 2) return 0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 0;
        end
        return 1;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_num(input int r, input int v);
        ReqNum[r*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic tick();
        @(posedge SysClk);
        #1;
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        ReqValid = '0;
        repeat (2) tick();
        Reset      = 1'b0;
        exp_checks = 0;
        exp_primes = 0;
    endtask

    // One request from an idle scheduler; k < 0 skips the latency check.
    task automatic run_one(input int r, input int num, input int exp_prime, input int k);
        int cyc;
        int rcyc;
        set_num(r, num);
        ReqValid[r] = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (ReqReady == '0 && cyc < 20);
        chk($sformatf("ready_lat n=%0d", num), cyc, 1);
        chk($sformatf("ready_onehot n=%0d", num), int'(ReqReady), 1 << r);
        chk($sformatf("grant_id n=%0d", num), int'(GrantId), r);
        tick();
        ReqValid[r] = 1'b0;
        chk($sformatf("busy_in_check n=%0d", num), int'(Busy), 1);
        rcyc = 1;
        while (RspValid == '0 && rcyc < 64) begin
            tick();
            rcyc++;
        end
        if (k >= 0) chk($sformatf("rsp_lat n=%0d", num), rcyc, k + 1);
        chk($sformatf("rsp_onehot n=%0d", num), int'(RspValid), 1 << r);
        chk($sformatf("rsp_prime n=%0d", num), int'(RspPrime), exp_prime);
        chk($sformatf("rsp_num n=%0d", num), int'(RspNum), num);
        exp_checks++;
        exp_primes += exp_prime;
        tick();
        chk($sformatf("checks_done n=%0d", num), int'(ChecksDone), exp_checks);
        chk($sformatf("primes_found n=%0d", num), int'(PrimesFound), exp_primes);
    endtask

    // Several requesters at once; non-sticky requesters drop after their acceptance edge.
    task automatic run_multi(input logic [NUM_REQ-1:0] init_mask, input logic [NUM_REQ-1:0] sticky,
                             input logic [NUM_REQ-1:0] late_mask, input int late_cyc,
                             input int want_g, input int want_r);
        logic [NUM_REQ-1:0] prev_rdy;
        int cyc;
        g_cnt    = 0;
        r_cnt    = 0;
        prev_rdy = '0;
        cyc      = 0;
        ReqValid = init_mask;
        while ((g_cnt < want_g || r_cnt < want_r) && cyc < 400) begin
            tick();
            cyc++;
            ReqValid = ReqValid & ~(prev_rdy & ~sticky);
            if (cyc == late_cyc) ReqValid = ReqValid | late_mask;
            prev_rdy = ReqReady;
            if (ReqReady != '0 && g_cnt < 8) begin
                g_ord[g_cnt] = onehot_idx(ReqReady);
                g_cnt++;
            end
            if (RspValid != '0 && r_cnt < 8) begin
                r_id[r_cnt]    = onehot_idx(RspValid);
                r_prime[r_cnt] = int'(RspPrime);
                r_num[r_cnt]   = int'(RspNum);
                r_cnt++;
            end
        end
        chk("multi_completed", (cyc < 400) ? 1 : 0, 1);
    endtask

    initial begin
        int cyc;
        int seen;
        vecs = '{'{0, 997, 1, 16}, '{1, 7, 1, 1}, '{2, 9, 0, 1}, '{3, 25, 0, 2},
                 '{0, 1023, 0, 1}, '{1, 0, 0, 1}, '{2, 1, 0, 1}, '{3, 2, 1, 1},
                 '{0, 3, 1, 1}, '{1, 4, 0, 1}, '{2, 961, 0, 15}, '{3, 1021, 1, 16},
                 '{0, 49, 0, 3}, '{1, 11, 1, 2}};

        Reset    = 1'b1;
        ReqValid = '0;
        ReqNum   = '0;
        repeat (2) tick();
        chk("rst_ready", int'(ReqReady), 0);
        chk("rst_rspvalid", int'(RspValid), 0);
        chk("rst_rspprime", int'(RspPrime), 0);
        chk("rst_rspnum", int'(RspNum), 0);
        chk("rst_grantid", int'(GrantId), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_checks", int'(ChecksDone), 0);
        chk("rst_primes", int'(PrimesFound), 0);
        Reset = 1'b0;

        foreach (vecs[i]) run_one(vecs[i].req, vecs[i].num, vecs[i].prime, vecs[i].k);

        // Four simultaneous requesters from pointer 0.
        do_reset();
        set_num(0, 9); set_num(1, 2); set_num(2, 0); set_num(3, 25);
        run_multi(4'b1111, 4'b0000, 4'b0000, 0, 4, 4);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("all4_grant%0d", i), g_ord[i], i);
            chk($sformatf("all4_rspid%0d", i), r_id[i], i);
        end
        chk("all4_prime0", r_prime[0], 0);
        chk("all4_prime1", r_prime[1], 1);
        chk("all4_prime2", r_prime[2], 0);
        chk("all4_prime3", r_prime[3], 0);
        chk("all4_num0", r_num[0], 9);
        chk("all4_num3", r_num[3], 25);
        chk("all4_checks", int'(ChecksDone), 4);
        chk("all4_primes", int'(PrimesFound), 1);
        set_num(0, 7); set_num(3, 11);
        run_multi(4'b1001, 4'b0000, 4'b0000, 0, 1, 0);
        chk("all4_ptr_wrapped", g_ord[0], 0);
        ReqValid = '0;

        // Requester 2 held continuously, requester 1 arrives during the check.
        do_reset();
        set_num(2, 997); set_num(1, 7);
        run_multi(4'b0100, 4'b0100, 4'b0010, 5, 3, 2);
        chk("rr_grant0", g_ord[0], 2);
        chk("rr_grant1", g_ord[1], 1);
        chk("rr_grant2", g_ord[2], 2);
        chk("rr_rsp0", r_id[0], 2);
        chk("rr_rsp1", r_id[1], 1);
        chk("rr_prime1", r_prime[1], 1);
        ReqValid = '0;

        // Withdraw on the GRANT cycle after a served request moved the pointer to 3.
        do_reset();
        run_one(2, 5, 1, 1);
        set_num(3, 13);
        ReqValid[3] = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (ReqReady == '0 && cyc < 20);
        chk("wd_ready", int'(ReqReady), 8);
        ReqValid[3] = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            if (RspValid != '0) seen++;
        end
        chk("wd_no_rsp", seen, 0);
        chk("wd_checks", int'(ChecksDone), 1);
        chk("wd_primes", int'(PrimesFound), 1);
        chk("wd_busy", int'(Busy), 0);
        chk("wd_grantid", int'(GrantId), 3);
        set_num(0, 7);
        run_multi(4'b1001, 4'b0000, 4'b0000, 0, 1, 0);
        chk("wd_ptr_zero", g_ord[0], 0);
        ReqValid = '0;

        // Reset in the middle of checking 997.
        do_reset();
        run_one(1, 3, 1, 1);
        set_num(0, 997);
        ReqValid[0] = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (ReqReady == '0 && cyc < 20);
        tick();
        ReqValid[0] = 1'b0;
        repeat (4) tick();
        Reset = 1'b1;
        tick();
        chk("mid_rst_ready", int'(ReqReady), 0);
        chk("mid_rst_rspvalid", int'(RspValid), 0);
        chk("mid_rst_rspnum", int'(RspNum), 0);
        chk("mid_rst_rspprime", int'(RspPrime), 0);
        chk("mid_rst_grantid", int'(GrantId), 0);
        chk("mid_rst_busy", int'(Busy), 0);
        chk("mid_rst_checks", int'(ChecksDone), 0);
        chk("mid_rst_primes", int'(PrimesFound), 0);
        Reset      = 1'b0;
        exp_checks = 0;
        exp_primes = 0;
        seen = 0;
        repeat (20) begin
            tick();
            if (RspValid != '0) seen++;
        end
        chk("mid_rst_no_rsp", seen, 0);
        run_one(0, 997, 1, 16);

        // Full sweep against the reference model.
        do_reset();
        for (int n = 0; n < 1024; n++) begin
            model_primes += ref_prime(n);
            run_one(0, n, ref_prime(n), -1);
        end
        chk("sweep_primes", int'(PrimesFound), 172);
        chk("sweep_model_primes", int'(PrimesFound), model_primes);
        chk("sweep_checks", int'(ChecksDone), 1024);

        chk("req_rsp_overlap", overlap, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
